// File: rtl/laplacian_pkg.sv
// Shared types and constants for the streaming 3x3 Laplacian filter.
package laplacian_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } lap_state_e;

    localparam logic LAP_MODE4 = 1'b0;   // 4c - (N+S+E+W)
    localparam logic LAP_MODE8 = 1'b1;   // 8c - (all eight neighbours)

    // Centre weights; every neighbour carries weight -1.
    localparam int LAP_W4_CENTRE = 4;
    localparam int LAP_W8_CENTRE = 8;

endpackage

// File: rtl/line_buffer.sv
// One raster line of delay: shift register that advances once per enable,
// tap is the sample written DEPTH enables ago.
module line_buffer #(
    parameter int DEPTH = 320,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] tap
);

    logic [DEPTH-1:0][WIDTH-1:0] sr;

    // shift the line one position per accepted (or flushed) pixel
    always_ff @(posedge clk_i) begin
        if (shift_en)
            sr <= {sr[DEPTH-2:0], din};
    end

    assign tap = sr[DEPTH-1];

endmodule

// File: rtl/laplacian_stream.sv
// Streaming 3x3 Laplacian edge filter with valid/ready on both sides.
// Optional build macro LAPLACIAN_CLAMP_EN saturates results to 0..2^PIX_W-1.
module laplacian_stream
    import laplacian_pkg::*;
#(
    parameter int IMG_W = 320,
    parameter int IMG_H = 240,
    parameter int PIX_W = 8,
    parameter int OUT_W = PIX_W + 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             mode_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [PIX_W-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [OUT_W-1:0] out_data_o,
    output logic             out_eof_o,
    output logic             busy_o
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    lap_state_e state, state_nxt;

    logic [CW-1:0] in_col, out_col;
    logic [RW-1:0] in_row, out_row;
    logic          mode_q;

    // win[row][col]: row 0 = oldest line, col 1 = most recent of the two stored columns
    logic [2:0][1:0][PIX_W-1:0] win;
    logic [PIX_W-1:0] pix_in, tap0, tap1;

    logic out_free, accept, flush_load, load, shift;
    logic in_last, in_has_out, border, out_last;
    logic [OUT_W-1:0] centre_w, edge_sum, corner_sum, raw, res;

    function automatic logic [OUT_W-1:0] ext(input logic [PIX_W-1:0] p);
        return {{(OUT_W-PIX_W){1'b0}}, p};
    endfunction

    assign out_free   = !out_valid_o || out_ready_i;
    assign accept     = in_valid_i && in_ready_o;
    // FLUSH drains the last IMG_W+1 results; stop once the eof result is parked
    assign flush_load = (state == FLUSH) && out_free && !(out_valid_o && out_eof_o);
    assign in_last    = (in_row == RW'(IMG_H-1)) && (in_col == CW'(IMG_W-1));
    // pixel index >= IMG_W+1 completes the window for index - IMG_W - 1
    assign in_has_out = (in_row > RW'(1)) || ((in_row == RW'(1)) && (in_col != '0));
    assign load       = (accept && in_has_out) || flush_load;
    assign shift      = accept || flush_load;
    assign pix_in     = accept ? in_data_i : '0;

    assign border   = (out_row == '0) || (out_row == RW'(IMG_H-1)) ||
                      (out_col == '0) || (out_col == CW'(IMG_W-1));
    assign out_last = (out_row == RW'(IMG_H-1)) && (out_col == CW'(IMG_W-1));

    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
        .clk_i(clk_i), .shift_en(shift), .din(pix_in), .tap(tap0)
    );
    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
        .clk_i(clk_i), .shift_en(shift), .din(tap0), .tap(tap1)
    );

    // kernel on the window plus the incoming column; modular arithmetic is exact in OUT_W bits
    always_comb begin
        centre_w   = (mode_q == LAP_MODE8) ? OUT_W'(LAP_W8_CENTRE) : OUT_W'(LAP_W4_CENTRE);
        edge_sum   = ext(win[0][1]) + ext(win[2][1]) + ext(win[1][0]) + ext(tap0);
        corner_sum = ext(win[0][0]) + ext(tap1) + ext(win[2][0]) + ext(pix_in);
        raw        = centre_w * ext(win[1][1]) - edge_sum -
                     ((mode_q == LAP_MODE8) ? corner_sum : '0);
`ifdef LAPLACIAN_CLAMP_EN
        if (raw[OUT_W-1])
            res = '0;
        else if (raw > ext({PIX_W{1'b1}}))
            res = ext({PIX_W{1'b1}});
        else
            res = raw;
`else
        res = raw;
`endif
    end

    // state register
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // next state and handshake outputs
    always_comb begin
        state_nxt  = state;
        in_ready_o = !rst_i && (state != FLUSH) && out_free;
        busy_o     = (state != IDLE);
        case (state)
            IDLE:  if (accept) state_nxt = FILL;
            FILL:  if (accept && in_row == RW'(1) && in_col == CW'(1)) state_nxt = RUN;
            RUN:   if (accept && in_last) state_nxt = FLUSH;
            FLUSH: if (out_valid_o && out_ready_i && out_eof_o) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // input raster position and per-frame mode capture
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            in_col <= '0;
            in_row <= '0;
            mode_q <= LAP_MODE4;
        end else if (accept) begin
            if (state == IDLE) mode_q <= mode_i;
            if (in_col == CW'(IMG_W-1)) begin
                in_col <= '0;
                in_row <= (in_row == RW'(IMG_H-1)) ? '0 : in_row + 1'b1;
            end else begin
                in_col <= in_col + 1'b1;
            end
        end
    end

    // 3x2 window shift registers fed by the line-buffer taps and the incoming pixel
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            win <= '0;
        end else if (shift) begin
            for (int r = 0; r < 3; r++) win[r][0] <= win[r][1];
            win[0][1] <= tap1;
            win[1][1] <= tap0;
            win[2][1] <= pix_in;
        end
    end

    // output register: holds until taken, borders forced to zero
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_eof_o   <= 1'b0;
            out_col     <= '0;
            out_row     <= '0;
        end else if (load) begin
            out_valid_o <= 1'b1;
            out_data_o  <= border ? '0 : res;
            out_eof_o   <= out_last;
            if (out_col == CW'(IMG_W-1)) begin
                out_col <= '0;
                out_row <= (out_row == RW'(IMG_H-1)) ? '0 : out_row + 1'b1;
            end else begin
                out_col <= out_col + 1'b1;
            end
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
            out_eof_o   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_laplacian_stream.sv
// Self-checking bench for laplacian_stream on a 4x3 frame.
module tb_laplacian_stream;

    localparam int TW = 4;
    localparam int TH = 3;
    localparam int NPIX = TW * TH;
    localparam int PW = 8;
    localparam int OW = PW + 4;
`ifdef LAPLACIAN_CLAMP_EN
    localparam bit CLAMP = 1'b1;
`else
    localparam bit CLAMP = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          mode_i = 1'b0;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic [PW-1:0] in_data_i = '0;
    logic          out_valid_o;
    logic          out_ready_i = 1'b0;
    logic [OW-1:0] out_data_o;
    logic          out_eof_o;
    logic          busy_o;

    laplacian_stream #(.IMG_W(TW), .IMG_H(TH), .PIX_W(PW), .OUT_W(OW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .mode_i(mode_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
        .out_eof_o(out_eof_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    typedef struct { int data; bit eof; } res_t;
    res_t got_q[$];
    int img[TH][TW];

    typedef struct {
        string name; int mode; int bg; int pr; int pc; int pv; int e11; int e12;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int cl(input int v);
        if (!CLAMP) return v;
        if (v < 0) return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    // reference: direct definition of the Laplacian on the frame array
    function automatic int ref_out(input int r, input int c, input int m);
        int s = 0;
        if (r == 0 || r == TH-1 || c == 0 || c == TW-1) return 0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                if (!(dr == 0 && dc == 0) && (m == 1 || dr == 0 || dc == 0))
                    s += img[r+dr][c+dc];
        return cl((m == 1 ? 8 : 4) * img[r][c] - s);
    endfunction

    task automatic check_frame(input string name, input int m);
        chk($sformatf("%s:count", name), got_q.size(), NPIX);
        for (int k = 0; k < got_q.size() && k < NPIX; k++) begin
            chk($sformatf("%s:data[%0d]", name, k), got_q[k].data, ref_out(k / TW, k % TW, m));
            chk($sformatf("%s:eof[%0d]", name, k), int'(got_q[k].eof), int'(k == NPIX-1));
        end
    endtask

    // drive one frame (or abort_after pixels), collect results; stall = % idle on each side
    task automatic run_frame(input int m, input int stall, input int abort_after,
                             output int first_cyc, output int eof_cyc);
        int sent = 0;
        int budget = 0;
        bit done = 0;
        bit held = 0;
        logic [OW-1:0] held_data = '0;
        got_q.delete();
        first_cyc = -1;
        eof_cyc = -1;
        while (!done) begin
            @(posedge clk_i); #1;
            if (sent < NPIX && (abort_after < 0 || sent < abort_after)) begin
                in_valid_i = ($urandom_range(0, 99) >= stall);
                in_data_i  = PW'(img[sent / TW][sent % TW]);
            end else begin
                in_valid_i = 1'b0;
            end
            mode_i      = (sent == 0) ? m[0] : 1'($urandom);
            out_ready_i = ($urandom_range(0, 99) >= stall);
            @(negedge clk_i);
            if (held) begin
                chk("stall:valid_held", int'(out_valid_o), 1);
                chk("stall:data_held", int'(out_data_o), int'(held_data));
            end
            if (in_valid_i && in_ready_o) begin
                if (sent == 0) first_cyc = cyc;
                sent++;
            end
            if (out_valid_o && out_ready_i) begin
                got_q.push_back('{int'($signed(out_data_o)), out_eof_o});
                if (out_eof_o) begin
                    done = 1;
                    eof_cyc = cyc;
                end
            end
            held = out_valid_o && !out_ready_i;
            held_data = out_data_o;
            if (abort_after >= 0 && sent == abort_after) done = 1;
            budget++;
            if (!done && budget > 2000) begin
                total++;
                bad++;
                $display("FAIL frame_timeout: no eof after %0d cycles, eof required", budget);
                done = 1;
            end
        end
    endtask

    vec_t vecs[6];
    int f1, e1, f2, e2;

    initial begin
        vecs[0] = '{"flat10_m0", 0, 10, 1, 1, 10, 0, 0};
        vecs[1] = '{"flat10_m1", 1, 10, 1, 1, 10, 0, 0};
        vecs[2] = '{"spike_m0", 0, 0, 1, 1, 100, cl(400), cl(-100)};
        vecs[3] = '{"spike_m1", 1, 0, 1, 1, 100, cl(800), cl(-100)};
        vecs[4] = '{"spike12_m0", 0, 0, 1, 2, 50, cl(-50), cl(200)};
        vecs[5] = '{"hole_m1", 1, 255, 1, 1, 0, cl(-2040), cl(255)};

        // reset state
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("reset:in_ready_during", int'(in_ready_o), 0);
        @(posedge clk_i); #1 rst_i = 1'b0;
        @(negedge clk_i);
        chk("reset:in_ready", int'(in_ready_o), 1);
        chk("reset:out_valid", int'(out_valid_o), 0);
        chk("reset:out_data", int'(out_data_o), 0);
        chk("reset:out_eof", int'(out_eof_o), 0);
        chk("reset:busy", int'(busy_o), 0);

        // directed image table
        foreach (vecs[i]) begin
            for (int r = 0; r < TH; r++)
                for (int c = 0; c < TW; c++)
                    img[r][c] = vecs[i].bg;
            img[vecs[i].pr][vecs[i].pc] = vecs[i].pv;
            run_frame(vecs[i].mode, 0, -1, f1, e1);
            check_frame(vecs[i].name, vecs[i].mode);
            if (got_q.size() == NPIX) begin
                chk({vecs[i].name, ":out11"}, got_q[5].data, vecs[i].e11);
                chk({vecs[i].name, ":out12"}, got_q[6].data, vecs[i].e12);
            end
        end

        // random images under random back-pressure and input gaps
        for (int it = 0; it < 8; it++) begin
            int m;
            m = int'($urandom_range(0, 1));
            for (int r = 0; r < TH; r++)
                for (int c = 0; c < TW; c++)
                    img[r][c] = int'($urandom_range(0, 255));
            run_frame(m, int'($urandom_range(20, 60)), -1, f1, e1);
            check_frame($sformatf("rand%0d", it), m);
        end

        // reset after five pixels, then a full frame
        for (int r = 0; r < TH; r++)
            for (int c = 0; c < TW; c++)
                img[r][c] = 200;
        run_frame(1, 0, 5, f1, e1);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        in_valid_i = 1'b0;
        @(negedge clk_i);
        chk("midreset:in_ready", int'(in_ready_o), 0);
        @(posedge clk_i); #1 rst_i = 1'b0;
        @(negedge clk_i);
        chk("midreset:busy", int'(busy_o), 0);
        chk("midreset:out_valid", int'(out_valid_o), 0);
        for (int r = 0; r < TH; r++)
            for (int c = 0; c < TW; c++)
                img[r][c] = int'($urandom_range(0, 255));
        run_frame(0, 30, -1, f1, e1);
        check_frame("after_reset", 0);

        // two back-to-back frames at full rate with a mode switch
        for (int r = 0; r < TH; r++)
            for (int c = 0; c < TW; c++)
                img[r][c] = int'($urandom_range(0, 255));
        run_frame(0, 0, -1, f1, e1);
        check_frame("b2b_f1", 0);
        chk("b2b:frame_cycles", e1 - f1 + 1, NPIX + TW + 2);
        for (int r = 0; r < TH; r++)
            for (int c = 0; c < TW; c++)
                img[r][c] = int'($urandom_range(0, 255));
        run_frame(1, 0, -1, f2, e2);
        check_frame("b2b_f2", 1);
        chk("b2b:next_accept", f2, e1 + 1);
        chk("b2b:frame2_cycles", e2 - f2 + 1, NPIX + TW + 2);
        @(posedge clk_i); #1;
        out_ready_i = 1'b0;
        @(negedge clk_i);
        chk("b2b:idle_busy", int'(busy_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
